// File: rtl/mux_varredura_nx1.sv
// Registered N-channel multiplexer for multiplexed 7-segment drivers.
// Supports manual channel select and auto-scan with dwell time, blanking and one-hot enables.
module mux_varredura_nx1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 50000,
    parameter int BLANK    = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      auto_en,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    output logic [WIDTH-1:0]          f,
    output logic [SEL_W-1:0]          ch_ativo,
    output logic [CHANNELS-1:0]       ch_en,
    output logic                      tick
);

    localparam int CNT_W = $clog2(DWELL);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    ch_d;
    logic [WIDTH-1:0]    f_d;
    logic [CHANNELS-1:0] onehot, en_d;
    logic                tick_d;
    logic                frozen;

    always_comb begin
        ch_d   = ch_ativo;
        cnt_d  = '0;
        tick_d = 1'b0;
        frozen = 1'b0;
        if (!auto_en) begin
            // Out-of-range selects leave the current channel in place.
            if (int'(sel) < CHANNELS) begin
                ch_d = sel;
            end
        end else if (hold) begin
            cnt_d  = cnt_q;
            frozen = 1'b1;
        end else if (int'(cnt_q) == DWELL - 1) begin
            tick_d = 1'b1;
            ch_d   = (int'(ch_ativo) == CHANNELS - 1) ? '0 : ch_ativo + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        f_d    = '0;
        onehot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_d == SEL_W'(k)) begin
                f_d       = data_in[k*WIDTH +: WIDTH];
                onehot[k] = 1'b1;
            end
        end

        if (frozen) begin
            en_d = ch_en;
        end else if (auto_en && (int'(cnt_d) < BLANK)) begin
            en_d = '0;
        end else begin
            en_d = onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ch_ativo <= '0;
            f        <= '0;
            ch_en    <= '0;
            tick     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ch_ativo <= ch_d;
            f        <= f_d;
            ch_en    <= en_d;
            tick     <= tick_d;
        end
    end

endmodule

// File: tb/tb_mux_varredura_nx1.sv
// Directed bench for mux_varredura_nx1: reset, manual select, auto scan, blanking, hold, mode switch.
// A second instance with BLANK=0 shares the stimulus and must never blank after reset.
module tb_mux_varredura_nx1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data_in = {4'hC, 4'hB, 4'hA};
    logic        auto_en = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        hold = 1'b0;

    logic [3:0]  f, f0;
    logic [1:0]  ch_ativo, ch_ativo0;
    logic [2:0]  ch_en, ch_en0;
    logic        tick, tick0;

    int n_total = 0;
    int n_bad   = 0;

    // Expected auto-scan trace for edges 1..12 after entering auto mode on channel 0.
    int ch_seq [12]   = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int tick_seq [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int en_seq [12]   = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0};
    int f_seq [12]    = '{10, 10, 10, 11, 11, 11, 11, 12, 12, 12, 12, 10};

    mux_varredura_nx1 #(.WIDTH(4), .CHANNELS(3), .DWELL(4), .BLANK(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .auto_en  (auto_en),
        .sel      (sel),
        .hold     (hold),
        .f        (f),
        .ch_ativo (ch_ativo),
        .ch_en    (ch_en),
        .tick     (tick)
    );

    mux_varredura_nx1 #(.WIDTH(4), .CHANNELS(3), .DWELL(4), .BLANK(0)) dut_noblank (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .auto_en  (auto_en),
        .sel      (sel),
        .hold     (hold),
        .f        (f0),
        .ch_ativo (ch_ativo0),
        .ch_en    (ch_en0),
        .tick     (tick0)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) check_val("noblank_en", 32'(ch_en0 == 3'b000), 32'd0);
    endtask

    task automatic check_out(input string tag, input int e_ch, input int e_f, input int e_en,
                             input int e_tick);
        check_val({tag, "_ch"}, 32'(ch_ativo), 32'(e_ch));
        check_val({tag, "_f"}, 32'(f), 32'(e_f));
        check_val({tag, "_en"}, 32'(ch_en), 32'(e_en));
        check_val({tag, "_tick"}, 32'(tick), 32'(e_tick));
    endtask

    initial begin
        // Reset held across two edges
        #12;
        check_out("rst", 0, 0, 0, 0);
        step();
        check_out("rst_edge", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Manual select and out-of-range select
        sel = 2'd2;
        step();
        check_out("man2", 2, 'hC, 3'b100, 0);
        sel = 2'd3;
        step();
        check_out("man3", 2, 'hC, 3'b100, 0);
        sel = 2'd0;
        step();
        check_out("man0", 0, 'hA, 3'b001, 0);

        // Auto scan with wrap and blanking
        auto_en = 1'b1;
        sel     = 2'd2;
        for (int e = 0; e < 12; e++) begin
            step();
            check_out($sformatf("scan%0d", e + 1), ch_seq[e], f_seq[e], en_seq[e], tick_seq[e]);
        end

        // Walk to channel 1 with counter 2
        for (int e = 0; e < 6; e++) step();
        check_out("pre_hold", 1, 'hB, 3'b010, 0);

        hold = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            check_out($sformatf("hold%0d", e), 1, 'hB, 3'b010, 0);
        end
        hold = 1'b0;
        step();
        check_out("rel1", 1, 'hB, 3'b010, 0);
        step();
        check_out("rel2", 2, 'hC, 3'b000, 1);

        // Back round to channel 1 (counter 0)
        for (int e = 0; e < 8; e++) step();
        check_out("to_ch1", 1, 'hB, 3'b000, 1);

        data_in = {4'hC, 4'h7, 4'hA};
        step();
        check_out("lat", 1, 'h7, 3'b010, 0);

        // Auto -> manual clears the counter; re-entering auto takes a full dwell
        auto_en = 1'b0;
        sel     = 2'd0;
        step();
        check_out("to_man", 0, 'hA, 3'b001, 0);
        auto_en = 1'b1;
        for (int e = 0; e < 3; e++) step();
        check_out("re_auto3", 0, 'hA, 3'b001, 0);
        step();
        check_out("re_auto4", 1, 'h7, 3'b000, 1);

        // Asynchronous reset mid-scan, between edges
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        step();
        check_out("post_rst1", 0, 'hA, 3'b001, 0);
        step();
        step();
        check_out("post_rst3", 0, 'hA, 3'b001, 0);
        step();
        check_out("post_rst4", 1, 'h7, 3'b000, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
